// File: rtl/opcode_decode_stage.sv
// Registered one-hot opcode decoder with a 2-entry skid buffer (valid/ready on both sides).
// Optional illegal-opcode flagging is enabled by defining OPDEC_ILLEGAL_EN.
`timescale 1ns/1ps
module opcode_decode_stage #(
  parameter int OP_W = 5,
  parameter int NUM_OUT = 32,
  parameter logic [NUM_OUT-1:0] LEGAL_MASK = {NUM_OUT{1'b1}}
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_opcode,
  input  logic               in_enable,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic [OP_W-1:0]    out_opcode,
  output logic               out_illegal
);

  logic               skid_valid;
  logic [NUM_OUT-1:0] skid_onehot;
  logic [OP_W-1:0]    skid_opcode;
  logic               skid_illegal;

  logic [NUM_OUT-1:0] dec_onehot;
  logic               dec_illegal;
  logic               accept;
  logic               drain;

  assign in_ready = ~skid_valid & ~reset;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

`ifdef OPDEC_ILLEGAL_EN
  logic dec_legal;

  always_comb begin
    dec_onehot = '0;
    dec_legal  = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (in_opcode == OP_W'(i)) begin
        dec_onehot[i] = in_enable;
        dec_legal     = LEGAL_MASK[i];
      end
    end
    // Opcodes beyond NUM_OUT never match above, so they fall out as illegal.
    if (!dec_legal) dec_onehot = '0;
    dec_illegal = ~dec_legal;
  end
`else
  logic unused_mask;
  assign unused_mask = ^LEGAL_MASK;

  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (in_opcode == OP_W'(i)) dec_onehot[i] = in_enable;
    end
    dec_illegal = 1'b0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_onehot   <= '0;
      out_opcode   <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_onehot  <= '0;
      skid_opcode  <= '0;
      skid_illegal <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so the only possible move is S -> O.
      if (drain) begin
        out_onehot   <= skid_onehot;
        out_opcode   <= skid_opcode;
        out_illegal  <= skid_illegal;
        skid_valid   <= 1'b0;
        skid_onehot  <= '0;
        skid_opcode  <= '0;
        skid_illegal <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || drain) begin
        out_valid   <= 1'b1;
        out_onehot  <= dec_onehot;
        out_opcode  <= in_opcode;
        out_illegal <= dec_illegal;
      end else begin
        skid_valid   <= 1'b1;
        skid_onehot  <= dec_onehot;
        skid_opcode  <= in_opcode;
        skid_illegal <= dec_illegal;
      end
    end else if (drain) begin
      out_valid   <= 1'b0;
      out_onehot  <= '0;
      out_opcode  <= '0;
      out_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_opcode_decode_stage.sv
// Directed self-checking bench for opcode_decode_stage: default instance plus a
// small OP_W=3/NUM_OUT=6 instance with a partial legal mask.
`timescale 1ns/1ps
module tb_opcode_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic        in_enable;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_onehot;
  logic [4:0]  out_opcode;
  logic        out_illegal;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [2:0]  b_in_opcode;
  logic        b_in_enable;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [5:0]  b_out_onehot;
  logic [2:0]  b_out_opcode;
  logic        b_out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  opcode_decode_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_enable(in_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
    .out_opcode(out_opcode), .out_illegal(out_illegal)
  );

  opcode_decode_stage #(.OP_W(3), .NUM_OUT(6), .LEGAL_MASK(6'b011111)) dut_b (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_opcode(b_in_opcode), .in_enable(b_in_enable),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_onehot(b_out_onehot),
    .out_opcode(b_out_opcode), .out_illegal(b_out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample/drive 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] one;
    reset = 1'b1; in_valid = 1'b1; in_opcode = 5'd3; in_enable = 1'b1; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_opcode = 3'd0; b_in_enable = 1'b1; b_out_ready = 1'b1;

    // T1 reset
    tick();
    chk("t1_in_ready_rst0", in_ready, 0);
    chk("t1_out_valid_rst0", out_valid, 0);
    chk("t1_onehot_rst0", out_onehot, 0);
    tick();
    chk("t1_in_ready_rst1", in_ready, 0);
    chk("t1_out_valid_rst1", out_valid, 0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("t1_in_ready_release", in_ready, 1);
    tick();
    chk("t1_out_valid_idle", out_valid, 0);

    // T2 sweep, one transfer per cycle
    in_valid = 1'b1; in_enable = 1'b1; out_ready = 1'b1;
    for (int op = 0; op < 32; op++) begin
      in_opcode = 5'(op);
      tick();
      one = 32'd1 << op;
      chk($sformatf("t2_valid_%0d", op), out_valid, 1);
      chk($sformatf("t2_onehot_%0d", op), out_onehot, one);
      chk($sformatf("t2_opcode_%0d", op), out_opcode, op);
      chk($sformatf("t2_in_ready_%0d", op), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("t2_drained_valid", out_valid, 0);
    chk("t2_drained_onehot", out_onehot, 0);
    chk("t2_drained_opcode", out_opcode, 0);

    // T3 enable gating
    in_valid = 1'b1; in_opcode = 5'd7; in_enable = 1'b0;
    tick();
    in_valid = 1'b0; in_enable = 1'b1;
    chk("t3_valid", out_valid, 1);
    chk("t3_onehot", out_onehot, 0);
    chk("t3_opcode", out_opcode, 7);
    tick();
    chk("t3_drain_valid", out_valid, 0);

    // T4 back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_opcode = 5'd3;
    tick();
    chk("t4_in_ready_1st", in_ready, 1);
    chk("t4_onehot_1st", out_onehot, 32'h8);
    in_opcode = 5'd9;
    tick();
    chk("t4_in_ready_full", in_ready, 0);
    chk("t4_onehot_hold", out_onehot, 32'h8);
    in_opcode = 5'd20;
    tick();
    chk("t4_hold_onehot", out_onehot, 32'h8);
    chk("t4_hold_opcode", out_opcode, 3);
    chk("t4_hold_in_ready", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("t4_second_valid", out_valid, 1);
    chk("t4_second_onehot", out_onehot, 32'h200);
    chk("t4_second_opcode", out_opcode, 9);
    chk("t4_in_ready_back", in_ready, 1);
    tick();
    chk("t4_empty_valid", out_valid, 0);

    // T6 reset mid-stall
    out_ready = 1'b0; in_valid = 1'b1; in_opcode = 5'd1;
    tick();
    in_opcode = 5'd2;
    tick();
    chk("t6_full_in_ready", in_ready, 0);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_onehot", out_onehot, 0);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    chk("t6_in_ready_release", in_ready, 1);
    tick();
    chk("t6_no_deliver_0", out_valid, 0);
    tick();
    chk("t6_no_deliver_1", out_valid, 0);

    // T5 small instance with partial legal mask
    b_in_valid = 1'b1; b_in_opcode = 3'd5;
    tick();
`ifdef OPDEC_ILLEGAL_EN
    chk("t5_op5_onehot", b_out_onehot, 0);
    chk("t5_op5_illegal", b_out_illegal, 1);
`else
    chk("t5_op5_onehot", b_out_onehot, 6'h20);
    chk("t5_op5_illegal", b_out_illegal, 0);
`endif
    chk("t5_op5_valid", b_out_valid, 1);
    b_in_opcode = 3'd6;
    tick();
    chk("t5_op6_onehot", b_out_onehot, 0);
`ifdef OPDEC_ILLEGAL_EN
    chk("t5_op6_illegal", b_out_illegal, 1);
`else
    chk("t5_op6_illegal", b_out_illegal, 0);
`endif
    chk("t5_op6_opcode", b_out_opcode, 6);
    b_in_opcode = 3'd4;
    tick();
    chk("t5_op4_onehot", b_out_onehot, 6'h10);
    chk("t5_op4_illegal", b_out_illegal, 0);
    b_in_valid = 1'b0;
    tick();
    chk("t5_drain_valid", b_out_valid, 0);
    chk("t5_drain_illegal", b_out_illegal, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
